// File: rtl/fetch_unit.sv
// fetch_unit: program RAM plus instruction sequencer feeding the control decoder.
// Program words arrive one per cycle on the load port. A program counter then steps
// through the RAM and shows {opcode, operand} for the current word to control.
// PcWait from control stalls the sequencer.
// Build option: define FETCH_WRAP_EN to wrap from the last word back to address 0.
// Without it, the sequencer halts after the last word.

package opcodes;
  typedef enum logic [3:0] {
    NOOP  = 4'h0,
    ADD   = 4'h1,
    SUB   = 4'h2,
    MULT  = 4'h3,
    AND   = 4'h4,
    OR    = 4'h5,
    XOR   = 4'h6,
    NOT   = 4'h7,
    SHL   = 4'h8,
    SHR   = 4'h9,
    LDIMM = 4'hA,
    LDACC = 4'hB,
    STACC = 4'hC,
    JMP   = 4'hD,
    WAIT0 = 4'hE,
    WAIT1 = 4'hF
  } opcodes_t;
endpackage

module fetch_unit #(
  parameter int ADDR_WIDTH = 5,
  parameter int IMM_WIDTH  = 8
) (
  input  logic                                          Clock,
  input  logic                                          Reset,
  input  logic                                          Load,
  input  logic                                          LoadValid,
  input  logic [$bits(opcodes::opcodes_t)+IMM_WIDTH-1:0] LoadData,
  output logic                                          LoadReady,
  input  logic                                          PcWait,
  output opcodes::opcodes_t                             OpCode,
  output logic [IMM_WIDTH-1:0]                          Operand,
  output logic [ADDR_WIDTH-1:0]                         Pc,
  output logic                                          Running,
  output logic                                          Halted
);

  localparam int OpWidth   = $bits(opcodes::opcodes_t);
  localparam int WordWidth = OpWidth + IMM_WIDTH;
  localparam int Depth     = 1 << ADDR_WIDTH;
  localparam logic [WordWidth-1:0] NoopWord = {opcodes::NOOP, {IMM_WIDTH{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, PRIME, RUN, HALT} state_t;

  state_t                  state;
  state_t                  nextState;
  logic [WordWidth-1:0]    mem [Depth];
  logic [WordWidth-1:0]    ir;
  logic [ADDR_WIDTH-1:0]   loadPtr;
  logic [ADDR_WIDTH-1:0]   nextPc;

  // Control strobes from the FSM to the datapath
  logic memWrite;
  logic loadExit;
  logic doPrime;
  logic doAdvance;
  logic doAbort;
  logic doHalt;

  assign nextPc = Pc + 1'b1;

  // State register
  always_ff @(posedge Clock) begin
    // NOTE: every clocked register uses non-blocking assignment so all flops
    // sample their inputs from the same edge, with no ordering races.
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state decode, datapath strobes and the externally visible outputs
  always_comb begin
    // NOTE: every output of this block gets a default first; any path that
    // missed an assignment would otherwise infer a latch.
    nextState = state;
    memWrite  = 1'b0;
    loadExit  = 1'b0;
    doPrime   = 1'b0;
    doAdvance = 1'b0;
    doAbort   = 1'b0;
    doHalt    = 1'b0;
    LoadReady = 1'b0;
    Running   = 1'b0;
    Halted    = 1'b0;
    OpCode    = opcodes::NOOP;
    Operand   = '0;

    case (state)
      IDLE: nextState = Load ? LOAD : PRIME;

      LOAD: begin
        LoadReady = 1'b1;
        // A word that arrives in the same cycle Load falls is still stored
        memWrite  = LoadValid;
        if (!Load) begin
          loadExit  = 1'b1;
          nextState = PRIME;
        end
      end

      PRIME: begin
        doPrime   = 1'b1;
        nextState = RUN;
      end

      RUN: begin
        Running = 1'b1;
        OpCode  = opcodes::opcodes_t'(ir[WordWidth-1 -: OpWidth]);
        Operand = ir[IMM_WIDTH-1:0];
        // A load request wins over both advancing and a stall
        if (Load) begin
          doAbort   = 1'b1;
          nextState = LOAD;
        end else if (!PcWait) begin
`ifdef FETCH_WRAP_EN
          // nextPc rolls over to 0 on its own, so the wrap needs no special case
          doAdvance = 1'b1;
`else
          if (&Pc) begin
            doHalt    = 1'b1;
            nextState = HALT;
          end else begin
            doAdvance = 1'b1;
          end
`endif
        end
      end

      HALT: begin
        Halted = 1'b1;
        if (Load) begin
          doAbort   = 1'b1;
          nextState = LOAD;
        end
      end

      default: nextState = IDLE;
    endcase
  end

  // Program counter, load pointer and instruction register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Pc      <= '0;
      loadPtr <= '0;
      ir      <= NoopWord;
    end else begin
      if (memWrite) loadPtr <= loadPtr + 1'b1;
      if (loadExit) begin
        Pc      <= '0;
        loadPtr <= '0;
      end
      if (doPrime) ir <= mem[0];
      if (doAdvance) begin
        Pc <= nextPc;
        ir <= mem[nextPc];
      end
      if (doAbort || doHalt) ir <= NoopWord;
      if (doAbort) Pc <= '0;
    end
  end

  // Program RAM write port
  always_ff @(posedge Clock) begin
    // NOTE: the RAM has no reset, so it maps onto plain memory. A program
    // loaded before a Reset stays valid after it.
    if (memWrite && !Reset) mem[loadPtr] <= LoadData;
  end

endmodule
